integrator_stats_divider: RTL and testbench
===========================================

Name: integrator_stats_divider

Overview:
- Downstream stage of the variable integrator in the sample-generator path.
- Consumes the accumulated sum, sum of squares and count, then divides sequentially to produce the signed mean and the mean square (optionally the RMS).
- Results go to the AXI-Lite register bank.
- One iterative divider, shared between both quotients; no DSP division.

Parameters:
- REG_DATA_WIDTH, 32, width of the count input/output.
- OUT_DATA_WIDTH, 64, width of accumulator inputs, divider datapath and mean outputs; must be even.

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- in_sum_sq  in  OUT_DATA_WIDTH  unsigned sum of squared samples.
- in_sum  in  OUT_DATA_WIDTH  signed (two's complement) sum of samples.
- in_n  in  REG_DATA_WIDTH  sample count plus one (upstream counter starts at 1).
- in_valid  in  1  level; high while upstream results are stable.
- busy  out  1  high from capture until the out_valid cycle, inclusive.
- out_mean  out  OUT_DATA_WIDTH  signed mean.
- out_mean_sq  out  OUT_DATA_WIDTH  unsigned mean square.
- out_rms  out  OUT_DATA_WIDTH/2  integer sqrt of out_mean_sq (see Optional Feature).
- out_count  out  REG_DATA_WIDTH  effective sample count D.
- out_valid  out  1  one-cycle pulse when outputs update.
- out_div_zero  out  1  high with out_valid when D==0.
- out_overrun  out  1  sticky; a capture request was dropped while busy.

Behaviour:
- Reset: rst, synchronous, active-high; clock clk.
- Reset values: all outputs 0; FSM to IDLE; in_valid edge register cleared to 0.
- Start event: rising edge of in_valid (registered previous value 0, current value 1). A level held high does not retrigger.
- Capture (start event in IDLE): latch in_sum, in_sum_sq and D = in_n − 1 (REG_DATA_WIDTH wrap; in_n==0 gives D = all-ones, passed through unchanged). Go to DIV_SUM.
- FSM states: IDLE → DIV_SUM → DIV_SQ → [SQRT] → DONE → IDLE.
- DIV_SUM:
  - Unsigned restoring division of |in_sum| by zero-extended D, one quotient bit per cycle, OUT_DATA_WIDTH cycles.
  - Result negated if in_sum was negative, so truncation is toward zero.
  - |most-negative value| is handled as unsigned 2^(W−1); no overflow.
- DIV_SQ: in_sum_sq / D by the same divider, OUT_DATA_WIDTH cycles.
- DONE: register all outputs, pulse out_valid for 1 cycle, return to IDLE.
- Latency: out_valid is high exactly 2*OUT_DATA_WIDTH+2 cycles after the capture edge (130 at default), plus OUT_DATA_WIDTH/2 when SQRT is present. Latency is fixed and independent of the data.
- D==0: the divider is skipped; out_mean = 0, out_mean_sq = 0, out_rms = 0, out_div_zero = 1. Latency is unchanged (the FSM still counts the cycles).
- Start event while busy: ignored. out_overrun is set to 1 and stays set until rst. The in-flight computation is unaffected.
- Outputs hold their values between out_valid pulses.
- Reset mid-operation: the computation is abandoned and no out_valid is generated.

Optional Feature:
- Macro: INTEGRATOR_STATS_RMS_SQRT_EN.
- Defined:
  - SQRT state inserted after DIV_SQ.
  - Non-restoring integer square root of the mean square, one result bit per cycle, OUT_DATA_WIDTH/2 cycles.
  - out_rms = floor(sqrt(out_mean_sq)).
- Undefined:
  - No SQRT state.
  - out_rms tied to 0.
  - Latency 2*OUT_DATA_WIDTH+2.

Decomposition:
- Package integrator_stats_pkg holds:
  - FSM state enum (IDLE, DIV_SUM, DIV_SQ, SQRT, DONE);
  - default width localparams;
  - latency constant functions used by the bench.
- Sub-module seq_udivider:
  - unsigned restoring divider;
  - start/done handshake, parameter WIDTH;
  - instantiated once and reused for both quotients.
- The square root stays inline in the top module under the macro.

Test Plan:
- Basic:
  - Stimulus: in_sum = −9, in_sum_sq = 29, in_n = 4, rising edge of in_valid.
  - Required response: after 130 cycles out_valid pulses with out_mean = −9/3 = −3, out_mean_sq = 9, out_count = 3, out_rms = 3 (macro on) or 0 (macro off).
- Truncation:
  - Stimulus: in_sum = −7, in_sum_sq = 50, in_n = 3 (D = 2).
  - Required response: out_mean = −3 (toward zero), out_mean_sq = 25, out_rms = 5.
- Divide by zero:
  - Stimulus: in_n = 1.
  - Required response: out_div_zero = 1, out_mean = 0, out_mean_sq = 0, same latency.
- Overrun:
  - Stimulus: second in_valid edge 20 cycles after the first.
  - Required response: the first result is correct, only one out_valid pulse occurs, out_overrun = 1 until rst.
- Level hold:
  - Stimulus: in_valid held high for 500 cycles.
  - Required response: exactly one out_valid pulse.
- Reset mid-operation:
  - Stimulus: rst asserted at cycle 40 of DIV_SUM.
  - Required response: all outputs 0, no out_valid; the next edge computes correctly.

Source files
------------

// File: rtl/integrator_stats_pkg.sv
// Shared definitions for the integrator statistics divider: state encoding, default widths, latency.
// Latency depends on INTEGRATOR_STATS_RMS_SQRT_EN, which adds the square-root stage.
package integrator_stats_pkg;

    localparam int DEFAULT_REG_DATA_WIDTH = 32;
    localparam int DEFAULT_OUT_DATA_WIDTH = 64;

    typedef enum logic [2:0] {
        IDLE,
        DIV_SUM,
        DIV_SQ,
        SQRT,
        DONE
    } state_e;

    // Cycles from the capture edge to the edge that raises out_valid.
    function automatic int div_latency(input int out_w);
        return 2 * out_w + 2;
    endfunction

    function automatic int result_latency(input int out_w);
`ifdef INTEGRATOR_STATS_RMS_SQRT_EN
        return div_latency(out_w) + out_w / 2;
`else
        return div_latency(out_w);
`endif
    endfunction

endpackage

// File: rtl/integrator_stats_divider_udiv.sv
// seq_udivider: unsigned restoring divider, one quotient bit per cycle, WIDTH cycles per quotient.
// start_i loads the operands; done_o pulses for one cycle while quotient_o is valid.
module seq_udivider #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic             done_o,
    output logic [WIDTH-1:0] quotient_o
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    logic             busy_q;
    logic             done_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] div_q;
    logic [WIDTH:0]   shifted;
    logic             fits;

    // The dividend shifts out of the top of quo_q while quotient bits enter at the bottom.
    always_comb begin
        shifted = {rem_q, quo_q[WIDTH-1]};
        fits    = (shifted >= {1'b0, div_q});
        rem_d   = fits ? WIDTH'(shifted - {1'b0, div_q}) : shifted[WIDTH-1:0];
        quo_d   = {quo_q[WIDTH-2:0], fits};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
            cnt_q  <= '0;
            rem_q  <= '0;
            quo_q  <= '0;
            div_q  <= '0;
        end else begin
            done_q <= 1'b0;
            if (start_i) begin
                busy_q <= 1'b1;
                cnt_q  <= CNT_W'(WIDTH);
                rem_q  <= '0;
                quo_q  <= dividend_i;
                div_q  <= divisor_i;
            end else if (busy_q) begin
                rem_q <= rem_d;
                quo_q <= quo_d;
                cnt_q <= cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end
            end
        end
    end

    assign done_o     = done_q;
    assign quotient_o = quo_q;

endmodule

// File: rtl/integrator_stats_divider.sv
// integrator_stats_divider: signed mean and mean square of integrator sums via one shared divider.
// Define INTEGRATOR_STATS_RMS_SQRT_EN to add the non-restoring square-root stage driving out_rms.
module integrator_stats_divider
    import integrator_stats_pkg::*;
#(
    parameter int REG_DATA_WIDTH = DEFAULT_REG_DATA_WIDTH,
    parameter int OUT_DATA_WIDTH = DEFAULT_OUT_DATA_WIDTH
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [OUT_DATA_WIDTH-1:0]   in_sum_sq,
    input  logic [OUT_DATA_WIDTH-1:0]   in_sum,
    input  logic [REG_DATA_WIDTH-1:0]   in_n,
    input  logic                        in_valid,
    output logic                        busy,
    output logic [OUT_DATA_WIDTH-1:0]   out_mean,
    output logic [OUT_DATA_WIDTH-1:0]   out_mean_sq,
    output logic [OUT_DATA_WIDTH/2-1:0] out_rms,
    output logic [REG_DATA_WIDTH-1:0]   out_count,
    output logic                        out_valid,
    output logic                        out_div_zero,
    output logic                        out_overrun
);

    localparam int W  = OUT_DATA_WIDTH;
    localparam int HW = OUT_DATA_WIDTH / 2;

    state_e                    state_q;
    logic                      in_valid_q;
    logic                      sum_neg_q;
    logic [W-1:0]              sum_sq_q;
    logic [REG_DATA_WIDTH-1:0] count_q;
    logic [W-1:0]              mean_q;

    logic [W-1:0]              out_mean_q;
    logic [W-1:0]              out_mean_sq_q;
    logic [REG_DATA_WIDTH-1:0] out_count_q;
    logic                      out_valid_q;
    logic                      out_div_zero_q;
    logic                      out_overrun_q;

    logic                      start_evt;
    logic                      div_zero;
    logic [REG_DATA_WIDTH-1:0] count_d;
    logic                      div_start;
    logic [W-1:0]              div_dividend;
    logic [W-1:0]              div_divisor;
    logic                      div_done;
    logic [W-1:0]              div_quotient;

    assign start_evt = in_valid && !in_valid_q;
    assign count_d   = in_n - REG_DATA_WIDTH'(1);
    assign div_zero  = (count_q == '0);
    assign div_start = ((state_q == IDLE) && start_evt) || ((state_q == DIV_SUM) && div_done);

    // First quotient is launched straight from the inputs on the capture edge; the second chains off done.
    always_comb begin
        div_dividend = sum_sq_q;
        div_divisor  = W'(count_q);
        if (state_q == IDLE) begin
            div_dividend = in_sum[W-1] ? -in_sum : in_sum;
            div_divisor  = W'(count_d);
        end
    end

    seq_udivider #(
        .WIDTH(W)
    ) u_div (
        .clk       (clk),
        .rst       (rst),
        .start_i   (div_start),
        .dividend_i(div_dividend),
        .divisor_i (div_divisor),
        .done_o    (div_done),
        .quotient_o(div_quotient)
    );

`ifdef INTEGRATOR_STATS_RMS_SQRT_EN
    localparam int RW    = HW + 2;
    localparam int SCNT_W = $clog2(HW + 1);

    logic [W-1:0]      msq_q;
    logic [W-1:0]      rad_q, rad_d;
    logic [RW-1:0]     srem_q, srem_d, srem_shift;
    logic [HW-1:0]     root_q, root_d;
    logic [SCNT_W-1:0] sq_cnt_q;
    logic [HW-1:0]     out_rms_q;

    // Non-restoring sqrt: the remainder sign picks add or subtract, and never needs restoring.
    always_comb begin
        srem_shift = {srem_q[RW-3:0], rad_q[W-1 -: 2]};
        srem_d     = srem_q[RW-1] ? srem_shift + {root_q, 2'b11} : srem_shift - {root_q, 2'b01};
        root_d     = {root_q[HW-2:0], ~srem_d[RW-1]};
        rad_d      = {rad_q[W-3:0], 2'b00};
    end
`endif

    // Control, working registers and the registered result bank; the divider still runs when D==0
    // so latency stays fixed, but its quotients are replaced by zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            in_valid_q     <= 1'b0;
            sum_neg_q      <= 1'b0;
            sum_sq_q       <= '0;
            count_q        <= '0;
            mean_q         <= '0;
            out_mean_q     <= '0;
            out_mean_sq_q  <= '0;
            out_count_q    <= '0;
            out_valid_q    <= 1'b0;
            out_div_zero_q <= 1'b0;
            out_overrun_q  <= 1'b0;
`ifdef INTEGRATOR_STATS_RMS_SQRT_EN
            msq_q          <= '0;
            rad_q          <= '0;
            srem_q         <= '0;
            root_q         <= '0;
            sq_cnt_q       <= '0;
            out_rms_q      <= '0;
`endif
        end else begin
            in_valid_q  <= in_valid;
            out_valid_q <= 1'b0;
            if (start_evt && (state_q != IDLE)) begin
                out_overrun_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (start_evt) begin
                        sum_neg_q <= in_sum[W-1];
                        sum_sq_q  <= in_sum_sq;
                        count_q   <= count_d;
                        state_q   <= DIV_SUM;
                    end
                end
                DIV_SUM: begin
                    if (div_done) begin
                        mean_q  <= sum_neg_q ? -div_quotient : div_quotient;
                        state_q <= DIV_SQ;
                    end
                end
                DIV_SQ: begin
                    if (div_done) begin
`ifdef INTEGRATOR_STATS_RMS_SQRT_EN
                        msq_q    <= div_quotient;
                        rad_q    <= div_quotient;
                        srem_q   <= '0;
                        root_q   <= '0;
                        sq_cnt_q <= SCNT_W'(HW);
                        state_q  <= SQRT;
`else
                        out_mean_q     <= div_zero ? '0 : mean_q;
                        out_mean_sq_q  <= div_zero ? '0 : div_quotient;
                        out_count_q    <= count_q;
                        out_div_zero_q <= div_zero;
                        out_valid_q    <= 1'b1;
                        state_q        <= DONE;
`endif
                    end
                end
`ifdef INTEGRATOR_STATS_RMS_SQRT_EN
                SQRT: begin
                    rad_q    <= rad_d;
                    srem_q   <= srem_d;
                    root_q   <= root_d;
                    sq_cnt_q <= sq_cnt_q - SCNT_W'(1);
                    if (sq_cnt_q == SCNT_W'(1)) begin
                        out_mean_q     <= div_zero ? '0 : mean_q;
                        out_mean_sq_q  <= div_zero ? '0 : msq_q;
                        out_rms_q      <= div_zero ? '0 : root_d;
                        out_count_q    <= count_q;
                        out_div_zero_q <= div_zero;
                        out_valid_q    <= 1'b1;
                        state_q        <= DONE;
                    end
                end
`endif
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

`ifdef INTEGRATOR_STATS_RMS_SQRT_EN
    assign out_rms = out_rms_q;
`else
    assign out_rms = '0;
`endif

    assign busy         = (state_q != IDLE);
    assign out_mean     = out_mean_q;
    assign out_mean_sq  = out_mean_sq_q;
    assign out_count    = out_count_q;
    assign out_valid    = out_valid_q;
    assign out_div_zero = out_div_zero_q;
    assign out_overrun  = out_overrun_q;

endmodule

// File: tb/tb_integrator_stats_divider.sv
// Self-checking bench for integrator_stats_divider: directed table, multi-cycle corner sequences
// and random operations checked against an arithmetic reference model.
module tb_integrator_stats_divider;
    import integrator_stats_pkg::*;

    localparam int RW = 32;
    localparam int W  = 64;
`ifdef INTEGRATOR_STATS_RMS_SQRT_EN
    localparam bit RMS_ON = 1'b1;
`else
    localparam bit RMS_ON = 1'b0;
`endif
    localparam int LAT   = 2 * W + 2 + (RMS_ON ? W / 2 : 0);
    localparam int BOUND = result_latency(W) + 20;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [W-1:0]  in_sum_sq = '0;
    logic [W-1:0]  in_sum = '0;
    logic [RW-1:0] in_n = '0;
    logic          in_valid = 1'b0;
    logic          busy;
    logic [W-1:0]  out_mean;
    logic [W-1:0]  out_mean_sq;
    logic [W/2-1:0] out_rms;
    logic [RW-1:0] out_count;
    logic          out_valid;
    logic          out_div_zero;
    logic          out_overrun;

    int errors = 0;
    int checks = 0;

    integrator_stats_divider #(
        .REG_DATA_WIDTH(RW),
        .OUT_DATA_WIDTH(W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_sum_sq   (in_sum_sq),
        .in_sum      (in_sum),
        .in_n        (in_n),
        .in_valid    (in_valid),
        .busy        (busy),
        .out_mean    (out_mean),
        .out_mean_sq (out_mean_sq),
        .out_rms     (out_rms),
        .out_count   (out_count),
        .out_valid   (out_valid),
        .out_div_zero(out_div_zero),
        .out_overrun (out_overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0]  sum;
        logic [W-1:0]  sumSq;
        logic [RW-1:0] n;
        logic [W-1:0]  expMean;
        logic [W-1:0]  expMeanSq;
        logic [W-1:0]  expRms;
        logic [RW-1:0] expCount;
        logic          expDz;
    } vec_t;

    vec_t table_v[7];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] isqrt(input logic [W-1:0] x);
        logic [W-1:0] r;
        logic [W-1:0] t;
        r = '0;
        for (int b = W / 2 - 1; b >= 0; b--) begin
            t = r | (64'd1 << b);
            if (t * t <= x) r = t;
        end
        return r;
    endfunction

    // Reference model straight from the arithmetic definition of the results.
    function automatic vec_t makeVec(input logic [W-1:0] s, input logic [W-1:0] sq, input logic [RW-1:0] n);
        vec_t v;
        logic [RW-1:0] d;
        longint sl;
        longint dl;
        d = n - 32'd1;
        v.sum = s;
        v.sumSq = sq;
        v.n = n;
        v.expCount = d;
        v.expDz = (d == 0);
        if (d == 0) begin
            v.expMean = '0;
            v.expMeanSq = '0;
            v.expRms = '0;
        end else begin
            sl = longint'(s);
            dl = longint'({32'd0, d});
            v.expMean = 64'(sl / dl);
            v.expMeanSq = sq / {32'd0, d};
            v.expRms = isqrt(v.expMeanSq);
        end
        return v;
    endfunction

    task automatic doReset();
        in_valid = 1'b0;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic applyStimulus(input vec_t v, input string tag);
        int cyc;
        in_valid = 1'b0;
        step();
        in_sum = v.sum;
        in_sum_sq = v.sumSq;
        in_n = v.n;
        in_valid = 1'b1;
        step();
        checkOutput({tag, ".busy_start"}, 64'(busy), 64'd1);
        in_valid = 1'b0;
        in_sum = {$urandom, $urandom};
        in_sum_sq = {$urandom, $urandom};
        in_n = $urandom;
        cyc = 0;
        while (!out_valid && cyc < BOUND) begin
            step();
            cyc++;
        end
        checkOutput({tag, ".latency"}, 64'(cyc), 64'(LAT));
        checkOutput({tag, ".mean"}, out_mean, v.expMean);
        checkOutput({tag, ".mean_sq"}, out_mean_sq, v.expMeanSq);
        checkOutput({tag, ".rms"}, 64'(out_rms), RMS_ON ? v.expRms : 64'd0);
        checkOutput({tag, ".count"}, 64'(out_count), 64'(v.expCount));
        checkOutput({tag, ".div_zero"}, 64'(out_div_zero), 64'(v.expDz));
        checkOutput({tag, ".busy_done"}, 64'(busy), 64'd1);
        step();
        checkOutput({tag, ".pulse_end"}, 64'(out_valid), 64'd0);
        checkOutput({tag, ".busy_idle"}, 64'(busy), 64'd0);
        checkOutput({tag, ".mean_hold"}, out_mean, v.expMean);
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int pulses;
        vec_t v;
        logic [W-1:0] gotMean;

        table_v[0] = '{64'hFFFF_FFFF_FFFF_FFF7, 64'd29, 32'd4, 64'hFFFF_FFFF_FFFF_FFFD, 64'd9, 64'd3, 32'd3, 1'b0};
        table_v[1] = '{64'hFFFF_FFFF_FFFF_FFF9, 64'd50, 32'd3, 64'hFFFF_FFFF_FFFF_FFFD, 64'd25, 64'd5, 32'd2, 1'b0};
        table_v[2] = '{64'd100, 64'd1000, 32'd1, 64'd0, 64'd0, 64'd0, 32'd0, 1'b1};
        table_v[3] = '{64'd7, 64'd10, 32'd4, 64'd2, 64'd3, 64'd1, 32'd3, 1'b0};
        table_v[4] = '{64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 32'd2,
                       64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF, 32'd1, 1'b0};
        table_v[5] = '{64'hFFFF_FFFF_0000_0000, 64'hFFFF_FFFE_0000_0001, 32'd0,
                       64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF, 64'hFFFF, 32'hFFFF_FFFF, 1'b0};
        table_v[6] = '{64'd100, 64'd1000, 32'd11, 64'd10, 64'd100, 64'd10, 32'd10, 1'b0};

        doReset();
        checkOutput("reset.mean", out_mean, 64'd0);
        checkOutput("reset.mean_sq", out_mean_sq, 64'd0);
        checkOutput("reset.rms", 64'(out_rms), 64'd0);
        checkOutput("reset.count", 64'(out_count), 64'd0);
        checkOutput("reset.valid", 64'(out_valid), 64'd0);
        checkOutput("reset.div_zero", 64'(out_div_zero), 64'd0);
        checkOutput("reset.overrun", 64'(out_overrun), 64'd0);
        checkOutput("reset.busy", 64'(busy), 64'd0);

        for (int i = 0; i < 7; i++) begin
            applyStimulus(table_v[i], $sformatf("vec%0d", i));
        end
        checkOutput("table.overrun", 64'(out_overrun), 64'd0);

        // Level hold: one edge, one result, no matter how long in_valid stays high.
        in_valid = 1'b0;
        step();
        in_sum = table_v[0].sum;
        in_sum_sq = table_v[0].sumSq;
        in_n = table_v[0].n;
        in_valid = 1'b1;
        pulses = 0;
        for (int c = 0; c < 500; c++) begin
            step();
            if (out_valid) pulses++;
        end
        in_valid = 1'b0;
        for (int c = 0; c < 20; c++) begin
            step();
            if (out_valid) pulses++;
        end
        checkOutput("hold.pulses", 64'(pulses), 64'd1);
        checkOutput("hold.mean", out_mean, table_v[0].expMean);
        checkOutput("hold.overrun", 64'(out_overrun), 64'd0);

        // Overrun: second edge 20 cycles into the first operation is dropped.
        in_valid = 1'b0;
        step();
        in_sum = table_v[1].sum;
        in_sum_sq = table_v[1].sumSq;
        in_n = table_v[1].n;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int c = 0; c < 18; c++) step();
        in_sum = 64'd5000;
        in_sum_sq = 64'd9999;
        in_n = 32'd6;
        in_valid = 1'b1;
        step();
        checkOutput("overrun.set", 64'(out_overrun), 64'd1);
        in_valid = 1'b0;
        pulses = 0;
        gotMean = '0;
        for (int c = 0; c < LAT + 40; c++) begin
            step();
            if (out_valid) begin
                pulses++;
                gotMean = out_mean;
                checkOutput("overrun.mean_sq", out_mean_sq, table_v[1].expMeanSq);
            end
        end
        checkOutput("overrun.pulses", 64'(pulses), 64'd1);
        checkOutput("overrun.mean", gotMean, table_v[1].expMean);
        checkOutput("overrun.sticky", 64'(out_overrun), 64'd1);
        doReset();
        checkOutput("overrun.cleared", 64'(out_overrun), 64'd0);

        // Reset 40 cycles into DIV_SUM abandons the operation.
        applyStimulus(table_v[6], "pre_abort");
        in_valid = 1'b0;
        step();
        in_sum = table_v[0].sum;
        in_sum_sq = table_v[0].sumSq;
        in_n = table_v[0].n;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int c = 0; c < 40; c++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        checkOutput("abort.mean", out_mean, 64'd0);
        checkOutput("abort.mean_sq", out_mean_sq, 64'd0);
        checkOutput("abort.count", 64'(out_count), 64'd0);
        checkOutput("abort.busy", 64'(busy), 64'd0);
        pulses = 0;
        for (int c = 0; c < LAT + 20; c++) begin
            step();
            if (out_valid) pulses++;
        end
        checkOutput("abort.pulses", 64'(pulses), 64'd0);
        applyStimulus(table_v[1], "post_abort");

        // Random operations against the reference model.
        for (int i = 0; i < 24; i++) begin
            logic [W-1:0] s;
            logic [W-1:0] sq;
            logic [RW-1:0] n;
            s = {$urandom, $urandom};
            if ($urandom_range(0, 2) == 0) s = 64'(signed'($urandom_range(0, 2000)) - 1000);
            sq = {$urandom, $urandom};
            if ($urandom_range(0, 2) == 0) sq = 64'($urandom_range(0, 100000));
            n = $urandom;
            if ($urandom_range(0, 1) == 0) n = 32'($urandom_range(0, 20));
            v = makeVec(s, sq, n);
            applyStimulus(v, $sformatf("rand%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
